write_merge_buffer: RTL and testbench
=====================================

WRITE_MERGE_BUFFER -- requirements
Module: write_merge_buffer

Interface
REQ-001 SHALL take parameter LINE_WIDTH, default 128, cache line width in bits, a multiple of WORD_WIDTH.
REQ-002 SHALL take parameter WORD_WIDTH, default 16, CPU word width in bits, a multiple of 8; WORDS = LINE_WIDTH/WORD_WIDTH, OFFSET_BITS = log2(WORDS).
REQ-003 SHALL take parameter ADDR_WIDTH, default 12, line-address width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cpu_write, input, 1 bit: write request, held by the CPU until cpu_resp.
REQ-007 SHALL have port cpu_addr, input, ADDR_WIDTH bits: target line address.
REQ-008 SHALL have port cpu_offset, input, OFFSET_BITS bits: word index within the line.
REQ-009 SHALL have port cpu_wdata, input, WORD_WIDTH bits: write word.
REQ-010 SHALL have port cpu_wmask, input, WORD_WIDTH/8 bits: byte enables, bit j is byte j of the word.
REQ-011 SHALL have port cpu_resp, output, 1 bit: one-cycle write acknowledge.
REQ-012 SHALL have port flush_req, input, 1 bit: level flush request, held until flush_done.
REQ-013 SHALL have port flush_done, output, 1 bit: one-cycle flush-complete pulse.
REQ-014 SHALL have ports mem_write (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, LINE_WIDTH), mem_byte_en (output, LINE_WIDTH/8) and mem_resp (input, 1): line write port to memory.
REQ-015 SHALL have port buf_valid, output, 1 bit: high when the buffer holds at least one valid byte.

Function
REQ-016 SHALL implement the states EMPTY, HOLD and FLUSH.
REQ-017 SHALL accept a write on a rising edge where cpu_write=1 and cpu_resp=0 and the state rules allow it; cpu_resp SHALL be 1 in the following cycle only.
REQ-018 SHALL map word k, byte j to line bits [(k*WORD_WIDTH/8+j)*8 +: 8] and to mem_byte_en bit k*WORD_WIDTH/8+j.
REQ-019 SHALL, on acceptance in EMPTY with nonzero mask: load line address, clear all byte valids, write enabled bytes, set their valids, and go to HOLD.
REQ-020 SHALL, on acceptance in EMPTY with zero mask: acknowledge without allocating and stay in EMPTY.
REQ-021 SHALL, in HOLD with cpu_addr equal to the held address: accept, overwrite enabled bytes, OR mask into the valids, and leave other bytes unchanged.
REQ-022 SHALL, in HOLD with cpu_addr different from the held address: not accept and go to FLUSH; the write is accepted in EMPTY after the flush.
REQ-023 SHALL go to FLUSH in the cycle after all byte valids become 1 (auto-flush of a full line).
REQ-024 SHALL, in HOLD with flush_req=1 and no acceptable write: go to FLUSH; a matching write in the same cycle takes priority and the flush follows.
REQ-025 SHALL, in FLUSH: hold mem_write=1 with mem_addr, mem_wdata and mem_byte_en stable until mem_resp; accept no writes.
REQ-026 SHALL, on mem_resp in FLUSH: clear all valids and go to EMPTY; flush_done SHALL pulse the next cycle if flush_req=1.
REQ-027 SHALL, on flush_req in EMPTY: pulse flush_done the next cycle with no memory access.
REQ-028 SHALL hold mem_write=0 outside FLUSH; mem_byte_en SHALL equal the valid vector at all times.

Reset
REQ-029 SHALL, while reset=1 (immediately, independent of clk): enter EMPTY, clear valids, address and data, and drive cpu_resp, flush_done, mem_write and buf_valid to 0.
REQ-030 SHALL, on reset during FLUSH: drop mem_write at once and discard the line, with no flush_done.

Verification
REQ-031 SHALL be covered by this scenario (LINE 128, WORD 16): write addr 0x010, off 3, data 0xBEEF, mask 11 -> cpu_resp next cycle; HOLD; mem_byte_en=0x00C0.
REQ-032 SHALL be covered by this scenario: then write addr 0x010, off 3, data 0x1234, mask 01 -> bits[63:48]=0xBE34; then write addr 0x020 -> FLUSH, mem_addr=0x010, mem_byte_en=0x00C0, no cpu_resp until after mem_resp, then 0x020 allocated.
REQ-033 SHALL be covered by this scenario: write all 8 words to addr 0x005 with mask 11 -> FLUSH in the cycle after the 8th accept, mem_byte_en=0xFFFF.
REQ-034 SHALL be covered by this scenario: flush_req in EMPTY -> flush_done one cycle later, mem_write stays 0; flush_req in HOLD -> mem_write, then after mem_resp flush_done, buf_valid=0.
REQ-035 SHALL be covered by this scenario: reset asserted mid-FLUSH with mem_resp never given -> mem_write=0 in the same cycle; after release state is EMPTY and buf_valid=0.
REQ-036 SHALL be covered by this scenario: write with mask 00 in EMPTY -> cpu_resp, buf_valid stays 0.

Source files
------------

// File: rtl/write_merge_buffer.sv
// write_merge_buffer: single-line write-combining buffer between a CPU write
// port and a line-wide memory write port.
//   clk, reset            : clock, asynchronous active-high reset
//   cpu_write/addr/offset : CPU word write request (held until cpu_resp)
//   cpu_wdata/wmask       : write word and its byte enables
//   cpu_resp              : one-cycle write acknowledge
//   flush_req/flush_done  : level flush request and one-cycle completion pulse
//   mem_*                 : line write to memory, held until mem_resp
//   buf_valid             : buffer holds at least one valid byte
module write_merge_buffer #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    localparam int unsigned WORDS       = LINE_WIDTH / WORD_WIDTH,
    localparam int unsigned OFFSET_BITS = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned WORD_BYTES  = WORD_WIDTH / 8,
    localparam int unsigned LINE_BYTES  = LINE_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_write,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [OFFSET_BITS-1:0] cpu_offset,
    input  logic [WORD_WIDTH-1:0]  cpu_wdata,
    input  logic [WORD_BYTES-1:0]  cpu_wmask,
    output logic                   cpu_resp,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [LINE_WIDTH-1:0]  mem_wdata,
    output logic [LINE_BYTES-1:0]  mem_byte_en,
    input  logic                   mem_resp,
    output logic                   buf_valid
);

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   data_q, data_d;
    logic [LINE_BYTES-1:0]   valid_q, valid_d;
    logic                    resp_q, resp_d;
    logic                    done_q, done_d;
    logic                    mem_write_q, mem_write_d;
    logic                    buf_valid_q, buf_valid_d;

    logic [LINE_BYTES-1:0]   line_mask;
    logic [LINE_WIDTH-1:0]   bit_mask;
    logic [LINE_WIDTH-1:0]   merged;
    logic                    wr_pend;

    // Project the word write onto line byte lanes and merge into held data
    always_comb begin
        line_mask = '0;
        bit_mask  = '0;
        for (int b = 0; b < int'(LINE_BYTES); b++) begin
            line_mask[b]     = (cpu_offset == OFFSET_BITS'(b / int'(WORD_BYTES)))
                               && cpu_wmask[b % int'(WORD_BYTES)];
            bit_mask[b*8 +: 8] = {8{line_mask[b]}};
        end
        merged = (data_q & ~bit_mask) | ({WORDS{cpu_wdata}} & bit_mask);
    end

    // A request already acknowledged this cycle is still being held; ignore it
    assign wr_pend = cpu_write && !resp_q;

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        resp_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (wr_pend && (|cpu_wmask)) begin
                    resp_d  = 1'b1;
                    addr_d  = cpu_addr;
                    data_d  = merged;
                    valid_d = line_mask;
                    state_d = S_HOLD;
                end else begin
                    if (wr_pend) begin
                        resp_d = 1'b1;
                    end
                    // done_q guard: flush_req is still high during the pulse
                    if (flush_req && !done_q) begin
                        done_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (&valid_q) begin
                    state_d = S_FLUSH;
                end else if (wr_pend && (cpu_addr == addr_q)) begin
                    resp_d  = 1'b1;
                    data_d  = merged;
                    valid_d = valid_q | line_mask;
                end else if (wr_pend || flush_req) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (mem_resp) begin
                    valid_d = '0;
                    state_d = S_EMPTY;
                    done_d  = flush_req;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        mem_write_d = (state_d == S_FLUSH);
        buf_valid_d = |valid_d;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            resp_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_write_q <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
            mem_write_q <= mem_write_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign cpu_resp    = resp_q;
    assign flush_done  = done_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = data_q;
    assign mem_byte_en = valid_q;
    assign buf_valid   = buf_valid_q;

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed bench for write_merge_buffer (LINE 128, WORD 16, ADDR 12).
module tb_write_merge_buffer;

    logic         clk;
    logic         reset;
    logic         cpu_write;
    logic [11:0]  cpu_addr;
    logic [2:0]   cpu_offset;
    logic [15:0]  cpu_wdata;
    logic [1:0]   cpu_wmask;
    logic         cpu_resp;
    logic         flush_req;
    logic         flush_done;
    logic         mem_write;
    logic [11:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_byte_en;
    logic         mem_resp;
    logic         buf_valid;

    int n_chk = 0;
    int n_bad = 0;
    int cyc;

    write_merge_buffer #(
        .LINE_WIDTH(128),
        .WORD_WIDTH(16),
        .ADDR_WIDTH(12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_offset  (cpu_offset),
        .cpu_wdata   (cpu_wdata),
        .cpu_wmask   (cpu_wmask),
        .cpu_resp    (cpu_resp),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_resp    (mem_resp),
        .buf_valid   (buf_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a write until acknowledged; cyc returns edges waited
    task automatic do_write(input logic [11:0] a, input logic [2:0] o,
                            input logic [15:0] d, input logic [1:0] m,
                            output int c);
        cpu_write  = 1'b1;
        cpu_addr   = a;
        cpu_offset = o;
        cpu_wdata  = d;
        cpu_wmask  = m;
        c = 0;
        do begin
            tick();
            c++;
        end while (!cpu_resp && c < 20);
        chk("wr_ack", 128'(cpu_resp), 128'(1));
        cpu_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_write = 1'b0; cpu_addr = '0; cpu_offset = '0;
        cpu_wdata = '0; cpu_wmask = '0; flush_req = 1'b0; mem_resp = 1'b0;
        tick(); tick();
        chk("rst_resp",  128'(cpu_resp),   128'(0));
        chk("rst_done",  128'(flush_done), 128'(0));
        chk("rst_mwr",   128'(mem_write),  128'(0));
        chk("rst_bval",  128'(buf_valid),  128'(0));
        chk("rst_ben",   128'(mem_byte_en), 128'(0));
        reset = 1'b0;
        tick();

        // First write allocates the line
        do_write(12'h010, 3'd3, 16'hBEEF, 2'b11, cyc);
        chk("w1_lat",  128'(cyc), 128'(1));
        chk("w1_bval", 128'(buf_valid), 128'(1));
        chk("w1_ben",  128'(mem_byte_en), 128'h00C0);
        chk("w1_data", 128'(mem_wdata[63:48]), 128'hBEEF);
        chk("w1_mwr",  128'(mem_write), 128'(0));
        tick();

        // Partial merge into the same word
        do_write(12'h010, 3'd3, 16'h1234, 2'b01, cyc);
        chk("w2_lat",  128'(cyc), 128'(1));
        chk("w2_data", 128'(mem_wdata[63:48]), 128'hBE34);
        chk("w2_ben",  128'(mem_byte_en), 128'h00C0);
        tick();

        // Different line forces a flush before acceptance
        cpu_write = 1'b1; cpu_addr = 12'h020; cpu_offset = 3'd0;
        cpu_wdata = 16'hAAAA; cpu_wmask = 2'b11;
        tick();
        chk("miss_mwr",  128'(mem_write), 128'(1));
        chk("miss_resp", 128'(cpu_resp), 128'(0));
        chk("miss_addr", 128'(mem_addr), 128'h010);
        chk("miss_ben",  128'(mem_byte_en), 128'h00C0);
        tick(); tick();
        chk("miss_hold_mwr",  128'(mem_write), 128'(1));
        chk("miss_hold_resp", 128'(cpu_resp), 128'(0));
        chk("miss_hold_data", 128'(mem_wdata[63:48]), 128'hBE34);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("miss_done_mwr",  128'(mem_write), 128'(0));
        chk("miss_done_resp", 128'(cpu_resp), 128'(0));
        chk("miss_done_bval", 128'(buf_valid), 128'(0));
        chk("miss_no_fdone",  128'(flush_done), 128'(0));
        tick();
        chk("alloc_resp", 128'(cpu_resp), 128'(1));
        chk("alloc_addr", 128'(mem_addr), 128'h020);
        chk("alloc_ben",  128'(mem_byte_en), 128'h0003);
        chk("alloc_data", 128'(mem_wdata[15:0]), 128'hAAAA);
        cpu_write = 1'b0;
        tick();

        // flush_req in HOLD
        flush_req = 1'b1;
        tick();
        chk("fh_mwr",  128'(mem_write), 128'(1));
        chk("fh_addr", 128'(mem_addr), 128'h020);
        chk("fh_done0", 128'(flush_done), 128'(0));
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("fh_done", 128'(flush_done), 128'(1));
        chk("fh_mwr0", 128'(mem_write), 128'(0));
        chk("fh_bval", 128'(buf_valid), 128'(0));
        flush_req = 1'b0;
        tick();
        chk("fh_pulse", 128'(flush_done), 128'(0));

        // Fill a whole line: auto-flush one cycle after the last accept
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            do_write(12'h005, 3'(k), 16'h1000 + 16'(k), 2'b11, cyc);
        end
        chk("full_ben",  128'(mem_byte_en), 128'hFFFF);
        chk("full_mwr0", 128'(mem_write), 128'(0));
        tick();
        chk("full_mwr",  128'(mem_write), 128'(1));
        chk("full_addr", 128'(mem_addr), 128'h005);
        chk("full_data", mem_wdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("full_end_mwr",  128'(mem_write), 128'(0));
        chk("full_end_done", 128'(flush_done), 128'(0));
        chk("full_end_bval", 128'(buf_valid), 128'(0));

        // flush_req in EMPTY: no memory access
        flush_req = 1'b1;
        tick();
        chk("fe_done", 128'(flush_done), 128'(1));
        chk("fe_mwr",  128'(mem_write), 128'(0));
        flush_req = 1'b0;
        tick();
        chk("fe_pulse", 128'(flush_done), 128'(0));

        // Zero-mask write in EMPTY
        do_write(12'h077, 3'd0, 16'hFFFF, 2'b00, cyc);
        chk("z_lat",  128'(cyc), 128'(1));
        chk("z_bval", 128'(buf_valid), 128'(0));
        chk("z_ben",  128'(mem_byte_en), 128'(0));
        tick();

        // Reset during FLUSH with no mem_resp
        do_write(12'h033, 3'd1, 16'h5555, 2'b10, cyc);
        chk("r_ben", 128'(mem_byte_en), 128'h0008);
        tick();
        flush_req = 1'b1;
        tick();
        chk("r_mwr1", 128'(mem_write), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("r_mwr_now",  128'(mem_write), 128'(0));
        chk("r_bval_now", 128'(buf_valid), 128'(0));
        flush_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("r_mwr_after",  128'(mem_write), 128'(0));
        chk("r_bval_after", 128'(buf_valid), 128'(0));
        chk("r_no_done",    128'(flush_done), 128'(0));
        do_write(12'h044, 3'd0, 16'h0102, 2'b11, cyc);
        chk("r_empty_lat",  128'(cyc), 128'(1));
        chk("r_empty_addr", 128'(mem_addr), 128'h044);
        chk("r_empty_ben",  128'(mem_byte_en), 128'h0003);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
